nn_stage_ctrl_fifo_p: RTL

//  Parametrised burst-buffer controller for one neural-net pipeline stage.
//  - Write side: accepts a ready/valid vector stream into an external data RAM, in slots of
//    (cfg_length+1) words; up to cfg_depth+1 slots.
//  - Read side: replays each full slot cfg_passes+1 times (one pass per tap sweep), then retires it.
//  - Generates RAM/tap addresses and delayed activity strobes for the downstream MAC pipeline.
//  - Generational upgrade: explicit read FSM, occupancy counter, read stall, configurable delays.

---
 rtl/nn_ctrl_pkg.sv | 21 ++
 rtl/nn_delay_line.sv | 30 +++
 rtl/nn_stage_ctrl_fifo_p.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the neural-net stage burst-buffer controller.
package nn_ctrl_pkg;

  localparam int unsigned SLOT_MAX_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  typedef logic [31:0] float_24_8;

  // Slot index increment that wraps back to 0 after the last configured slot.
  function automatic logic [SLOT_MAX_W-1:0] slot_wrap_inc(
    input logic [SLOT_MAX_W-1:0] slot,
    input logic [SLOT_MAX_W-1:0] last
  );
    return (slot == last) ? '0 : slot + SLOT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/nn_delay_line.sv
// Fixed-length shift register with synchronous active-high clear.
module nn_delay_line #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [N*W-1:0] sr_q;

  generate
    if (N == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= d_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= {sr_q[(N-1)*W-1:0], d_i};
      end
    end
  endgenerate

  assign q_o = sr_q[N*W-1 -: W];

endmodule

// File: rtl/nn_stage_ctrl_fifo_p.sv
// Burst-buffer controller: fills RAM slots from a ready/valid stream and replays
// each full slot a configurable number of passes before retiring it.
module nn_stage_ctrl_fifo_p
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned LW      = 3,
  parameter int unsigned DPW     = 3,
  parameter int unsigned PW      = 2,
  parameter int unsigned TW      = 4,
  parameter int unsigned ACT_DLY = 12,
  parameter int unsigned WB_DLY  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LW-1:0]      cfg_length,
  input  logic [DPW-1:0]     cfg_depth,
  input  logic [PW-1:0]      cfg_passes,
  input  logic [DW-1:0]      in_data,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic               rd_stall,
  output logic               wr_en,
  output logic [DPW+LW-1:0]  wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               rd_en,
  output logic [DPW+LW-1:0]  rd_addr,
  output logic [TW-1:0]      tap_addr,
  output logic [TW-1:0]      tap_wr_addr,
  output logic               pass_last,
  output logic               slot_retire,
  output logic               active,
  output logic [DPW:0]       occupancy
);

  localparam int unsigned OW = DPW + 1;

  logic [LW-1:0]  wr_word_q, wr_word_d;
  logic [DPW-1:0] wr_slot_q, wr_slot_d;
  logic [OW-1:0]  occ_q, occ_d;
  logic           fill_c;

  logic [LW-1:0]  rd_word_q, rd_word_d;
  logic [DPW-1:0] rd_slot_q, rd_slot_d;
  logic [PW-1:0]  pass_q, pass_d;
  logic [TW-1:0]  tap_q, tap_d;
  logic           word_last_c;

  rd_state_e      state_q, state_d;

  assign in_rdy    = (occ_q != (OW'(cfg_depth) + OW'(1)));
  assign wr_en     = in_vld & in_rdy;
  assign wr_data   = in_data;
  assign wr_addr   = {wr_slot_q, wr_word_q};
  assign rd_addr   = {rd_slot_q, rd_word_q};
  assign tap_addr  = tap_q;
  assign occupancy = occ_q;

  // Write-side word/slot counters; a slot becomes full on its last word.
  always_comb begin
    wr_word_d = wr_word_q;
    wr_slot_d = wr_slot_q;
    fill_c    = 1'b0;
    if (wr_en) begin
      if (wr_word_q == cfg_length) begin
        fill_c    = 1'b1;
        wr_word_d = '0;
        wr_slot_d = DPW'(slot_wrap_inc(SLOT_MAX_W'(wr_slot_q), SLOT_MAX_W'(cfg_depth)));
      end else begin
        wr_word_d = wr_word_q + LW'(1);
      end
    end
  end

  // Simultaneous fill and retire leave occupancy unchanged.
  always_comb begin
    occ_d = occ_q;
    if (fill_c && !slot_retire)      occ_d = occ_q + OW'(1);
    else if (!fill_c && slot_retire) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stall freezes the FSM; leaving READ only when the last full slot retires.
  always_comb begin
    state_d = state_q;
    if (!rd_stall) begin
      case (state_q)
        IDLE:    if (occ_q != '0) state_d = READ;
        READ:    if (slot_retire && (occ_d == '0)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign word_last_c = (rd_word_q == cfg_length);

  always_comb begin
    rd_en       = 1'b0;
    pass_last   = 1'b0;
    slot_retire = 1'b0;
    if (state_q == READ && !rd_stall) begin
      rd_en = 1'b1;
      if (word_last_c) begin
        pass_last   = 1'b1;
        slot_retire = (pass_q == cfg_passes);
      end
    end
  end

  // Read-side word, tap, pass and slot counters advance only on rd_en.
  always_comb begin
    rd_word_d = rd_word_q;
    rd_slot_d = rd_slot_q;
    pass_d    = pass_q;
    tap_d     = tap_q;
    if (rd_en) begin
      if (word_last_c) begin
        rd_word_d = '0;
        tap_d     = '0;
        if (pass_q == cfg_passes) begin
          pass_d    = '0;
          rd_slot_d = DPW'(slot_wrap_inc(SLOT_MAX_W'(rd_slot_q), SLOT_MAX_W'(cfg_depth)));
        end else begin
          pass_d = pass_q + PW'(1);
        end
      end else begin
        rd_word_d = rd_word_q + LW'(1);
        tap_d     = tap_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_word_q <= '0;
      wr_slot_q <= '0;
      occ_q     <= '0;
      rd_word_q <= '0;
      rd_slot_q <= '0;
      pass_q    <= '0;
      tap_q     <= '0;
    end else begin
      wr_word_q <= wr_word_d;
      wr_slot_q <= wr_slot_d;
      occ_q     <= occ_d;
      rd_word_q <= rd_word_d;
      rd_slot_q <= rd_slot_d;
      pass_q    <= pass_d;
      tap_q     <= tap_d;
    end
  end

  nn_delay_line #(.W(1), .N(ACT_DLY)) u_act_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (rd_en),
    .q_o   (active)
  );

  nn_delay_line #(.W(TW), .N(WB_DLY)) u_wb_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (tap_q),
    .q_o   (tap_wr_addr)
  );

endmodule
